// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode results with write-back bypass,
// inserts bubbles on load-use hazards or flush, and counts hazard bubbles.
module id_ex_stage #(
    parameter int data_width   = 32,
    parameter int select_width = 5,
    parameter int count_width  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [select_width-1:0] id_read_sel_1,
    input  logic [select_width-1:0] id_read_sel_2,
    input  logic [data_width-1:0]   id_read_data_1,
    input  logic [data_width-1:0]   id_read_data_2,
    input  logic [data_width-1:0]   id_imm,
    input  logic [select_width-1:0] id_write_address,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic                    id_alu_src,
    input  logic [3:0]              id_alu_op,
    input  logic                    wb_reg_write,
    input  logic [select_width-1:0] wb_write_address,
    input  logic [data_width-1:0]   wb_write_data,
    output logic                    ex_valid,
    output logic [data_width-1:0]   ex_read_data_1,
    output logic [data_width-1:0]   ex_read_data_2,
    output logic [data_width-1:0]   ex_imm,
    output logic [select_width-1:0] ex_read_sel_1,
    output logic [select_width-1:0] ex_read_sel_2,
    output logic [select_width-1:0] ex_write_address,
    output logic                    ex_reg_write,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_alu_src,
    output logic [3:0]              ex_alu_op,
    output logic                    load_use_stall,
    output logic [count_width-1:0]  bubble_count
);

    logic [data_width-1:0] byp_data_1;
    logic [data_width-1:0] byp_data_2;
    logic                  load_en;
    logic                  bubble;
    logic                  take;

    // Register file writes land at the clock edge, so a same-cycle read sees stale data.
    always_comb begin
        byp_data_1 = id_read_data_1;
        byp_data_2 = id_read_data_2;
        if (wb_reg_write && id_read_sel_1 != '0 && wb_write_address == id_read_sel_1)
            byp_data_1 = wb_write_data;
        if (wb_reg_write && id_read_sel_2 != '0 && wb_write_address == id_read_sel_2)
            byp_data_2 = wb_write_data;
    end

    assign load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_write_address != '0) &
                            ((ex_write_address == id_read_sel_1) |
                             (ex_write_address == id_read_sel_2));

    // flush overrides stall; stall masks the hazard bubble
    assign load_en = flush | ~stall;
    assign bubble  = flush | load_use_stall;
    assign take    = ~bubble & id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_read_data_1   <= '0;
            ex_read_data_2   <= '0;
            ex_imm           <= '0;
            ex_read_sel_1    <= '0;
            ex_read_sel_2    <= '0;
            ex_write_address <= '0;
            ex_reg_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_alu_src       <= 1'b0;
            ex_alu_op        <= '0;
            bubble_count     <= '0;
        end else if (load_en) begin
            ex_valid         <= take;
            ex_read_data_1   <= bubble ? '0 : byp_data_1;
            ex_read_data_2   <= bubble ? '0 : byp_data_2;
            ex_imm           <= bubble ? '0 : id_imm;
            ex_read_sel_1    <= bubble ? '0 : id_read_sel_1;
            ex_read_sel_2    <= bubble ? '0 : id_read_sel_2;
            ex_write_address <= bubble ? '0 : id_write_address;
            ex_reg_write     <= take & id_reg_write;
            ex_mem_read      <= take & id_mem_read;
            ex_mem_write     <= take & id_mem_write;
            ex_alu_src       <= take & id_alu_src;
            ex_alu_op        <= take ? id_alu_op : 4'd0;
            // only hazard bubbles are counted, not flushes
            if (!flush && load_use_stall && bubble_count != '1)
                bubble_count <= bubble_count + count_width'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage against a rule-level model of the EX slot.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int CW = 8;

    logic clk, rst, stall, flush, id_valid;
    logic [SW-1:0] id_read_sel_1, id_read_sel_2, id_write_address, wb_write_address;
    logic [DW-1:0] id_read_data_1, id_read_data_2, id_imm, wb_write_data;
    logic id_reg_write, id_mem_read, id_mem_write, id_alu_src, wb_reg_write;
    logic [3:0] id_alu_op;
    logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, load_use_stall;
    logic [DW-1:0] ex_read_data_1, ex_read_data_2, ex_imm;
    logic [SW-1:0] ex_read_sel_1, ex_read_sel_2, ex_write_address;
    logic [3:0] ex_alu_op;
    logic [CW-1:0] bubble_count;

    id_ex_stage #(.data_width(DW), .select_width(SW), .count_width(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_read_sel_1(id_read_sel_1), .id_read_sel_2(id_read_sel_2),
        .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
        .id_imm(id_imm), .id_write_address(id_write_address),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .wb_reg_write(wb_reg_write), .wb_write_address(wb_write_address),
        .wb_write_data(wb_write_data), .ex_valid(ex_valid),
        .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2),
        .ex_imm(ex_imm), .ex_read_sel_1(ex_read_sel_1), .ex_read_sel_2(ex_read_sel_2),
        .ex_write_address(ex_write_address), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] d1, d2, imm;
        logic [SW-1:0] s1, s2, wa;
        logic          rw, mr, mw, as;
        logic [3:0]    op;
        logic [CW-1:0] cnt;
    } ex_t;

    ex_t  m;
    ex_t  q_st[$];
    logic q_lus[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the EX slot must hold after the next edge, from the stage's rules.
    task automatic cycle();
        ex_t n;
        logic hz;
        hz = id_valid && m.valid && m.mr && m.wa != 0 &&
             (m.wa == id_read_sel_1 || m.wa == id_read_sel_2);
        q_lus.push_back(hz);
        n = m;
        if (rst) n = '0;
        else if (flush || (!stall && hz)) begin
            n = '0;
            n.cnt = m.cnt;
            if (!flush && m.cnt != {CW{1'b1}}) n.cnt = m.cnt + 1;
        end else if (!stall) begin
            n.valid = id_valid;
            n.d1  = (wb_reg_write && id_read_sel_1 != 0 && wb_write_address == id_read_sel_1)
                    ? wb_write_data : id_read_data_1;
            n.d2  = (wb_reg_write && id_read_sel_2 != 0 && wb_write_address == id_read_sel_2)
                    ? wb_write_data : id_read_data_2;
            n.imm = id_imm;
            n.s1  = id_read_sel_1;
            n.s2  = id_read_sel_2;
            n.wa  = id_write_address;
            n.rw  = id_valid & id_reg_write;
            n.mr  = id_valid & id_mem_read;
            n.mw  = id_valid & id_mem_write;
            n.as  = id_valid & id_alu_src;
            n.op  = id_valid ? id_alu_op : 4'd0;
        end
        m = n;
        q_st.push_back(m);
        @(posedge clk);
        #3;
    endtask

    task automatic clear_in();
        {stall, flush, id_valid, id_reg_write, id_mem_read, id_mem_write, id_alu_src} = '0;
        {id_read_sel_1, id_read_sel_2, id_write_address, id_alu_op} = '0;
        {id_read_data_1, id_read_data_2, id_imm} = '0;
        {wb_reg_write, wb_write_address, wb_write_data} = '0;
    endtask

    task automatic rand_in();
        id_valid       = ($urandom_range(0, 9) < 8);
        id_read_sel_1  = SW'($urandom_range(0, 3));
        id_read_sel_2  = SW'($urandom_range(0, 3));
        id_write_address = SW'($urandom_range(0, 3));
        id_read_data_1 = $urandom;
        id_read_data_2 = $urandom;
        id_imm         = $urandom;
        id_reg_write   = 1'($urandom);
        id_mem_read    = 1'($urandom);
        id_mem_write   = 1'($urandom);
        id_alu_src     = 1'($urandom);
        id_alu_op      = 4'($urandom);
        wb_reg_write   = 1'($urandom);
        wb_write_address = SW'($urandom_range(0, 3));
        wb_write_data  = $urandom;
    endtask

    // State monitor: EX outputs just after each edge.
    initial begin
        ex_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_st.size() != 0) begin
                e = q_st.pop_front();
                chk("ex_valid", 64'(ex_valid), 64'(e.valid));
                chk("ex_read_data_1", 64'(ex_read_data_1), 64'(e.d1));
                chk("ex_read_data_2", 64'(ex_read_data_2), 64'(e.d2));
                chk("ex_imm", 64'(ex_imm), 64'(e.imm));
                chk("ex_read_sel_1", 64'(ex_read_sel_1), 64'(e.s1));
                chk("ex_read_sel_2", 64'(ex_read_sel_2), 64'(e.s2));
                chk("ex_write_address", 64'(ex_write_address), 64'(e.wa));
                chk("ex_reg_write", 64'(ex_reg_write), 64'(e.rw));
                chk("ex_mem_read", 64'(ex_mem_read), 64'(e.mr));
                chk("ex_mem_write", 64'(ex_mem_write), 64'(e.mw));
                if (e.valid) begin
                    chk("ex_alu_src", 64'(ex_alu_src), 64'(e.as));
                    chk("ex_alu_op", 64'(ex_alu_op), 64'(e.op));
                end
                chk("bubble_count", 64'(bubble_count), 64'(e.cnt));
            end
        end
    end

    // Hazard monitor: combinational stall just before the edge that acts on it.
    initial begin
        logic l;
        forever begin
            @(negedge clk);
            #4;
            if (q_lus.size() != 0) begin
                l = q_lus.pop_front();
                chk("load_use_stall", 64'(load_use_stall), 64'(l));
            end
        end
    end

    initial begin
        m = '0;
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        #3;
        cycle(); cycle();
        rst = 1'b0;
        // basic capture
        id_valid = 1; id_read_sel_1 = 10; id_read_sel_2 = 12; id_read_data_1 = 7;
        id_read_data_2 = 9; id_imm = 4; id_write_address = 30; id_reg_write = 1;
        cycle();
        // bypass, then address 0 never bypassed
        wb_reg_write = 1; wb_write_address = 30; wb_write_data = 935;
        id_read_sel_1 = 30; id_read_data_1 = 0; id_read_sel_2 = 10; id_read_data_2 = 55;
        cycle();
        wb_write_address = 0; id_read_sel_1 = 0; id_read_data_1 = 3;
        cycle();
        wb_reg_write = 0;
        // load-use: one bubble then capture
        id_mem_read = 1; id_write_address = 29; id_read_sel_1 = 1; id_read_sel_2 = 2;
        cycle();
        id_mem_read = 0; id_write_address = 7; id_read_sel_1 = 3; id_read_sel_2 = 29;
        cycle(); cycle();
        // stall holds while inputs change, then flush
        stall = 1;
        repeat (3) begin rand_in(); cycle(); end
        clear_in(); flush = 1; id_valid = 1; id_reg_write = 1;
        cycle();
        flush = 0;
        // flush+stall with pending hazard, then reset during stall with hazard
        id_mem_read = 1; id_write_address = 29; cycle();
        id_mem_read = 0; id_read_sel_1 = 29; flush = 1; stall = 1; cycle();
        flush = 0; stall = 0; id_mem_read = 1; id_read_sel_1 = 1; cycle();
        id_read_sel_1 = 29; stall = 1; cycle(); cycle();
        rst = 1; cycle();
        rst = 0; stall = 0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 12) == 0);
            cycle();
        end
        // saturation: back-to-back dependent loads
        clear_in(); rst = 0;
        id_valid = 1; id_mem_read = 1; id_write_address = 5; id_read_sel_1 = 5;
        for (int i = 0; i < 2 * ((1 << CW) + 8); i++) cycle();
        clear_in();
        repeat (2) @(posedge clk);
        checks++;
        if (q_st.size() != 0 || q_lus.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q_st.size(), q_lus.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
